// File: rtl/rv_pkg.sv
// rv_pkg: shared fetch-path types, constants and address helpers
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_BUBBLE = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small circular buffer of fetched {pc, inst} pairs; clear beats push/pop
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  fetch_entry_t             wdata_i,
  output fetch_entry_t             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_i);
      rd_q  <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= wdata_i;
  end
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC owner issuing one-outstanding imem requests into a decode-side FIFO
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_encoding,
  output logic [31:0] pc,
  output logic        inst_valid
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  fetch_state_e state_q;
  logic [31:0] fetch_pc_q, imem_addr_q, target_pc;
  logic imem_req_q, discard_q;
  logic rsp_ok, push, pop, full, empty, room;
  logic [CW-1:0] count, count_nxt;
  fetch_entry_t head;
  // a request still pending in WAIT (redirected before gnt) has no response yet
  assign rsp_ok    = state_q == WAIT && !imem_req_q && imem_rvalid;
  assign push      = rsp_ok && !discard_q && !redirect;
  assign pop       = inst_valid && !stall && !redirect;
  assign count_nxt = redirect ? '0 : count + CW'(push) - CW'(pop);
  assign room      = count_nxt < CW'(BUF_DEPTH);
  assign target_pc = redirect ? word_align(redirect_pc) : fetch_pc_q;
  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push && (!full || pop)),
    .pop_i   (pop),
    .clear_i (redirect),
    .wdata_i ('{pc: imem_addr_q, inst: imem_rdata}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_addr_q <= RESET_PC;
      imem_req_q  <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          fetch_pc_q <= target_pc;
          if (room) begin
            state_q     <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= target_pc;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            state_q    <= WAIT;
            imem_req_q <= 1'b0;
            discard_q  <= redirect;
            fetch_pc_q <= redirect ? target_pc : fetch_pc_q + PC_STEP;
          end else if (redirect) begin
            state_q    <= WAIT;
            discard_q  <= 1'b1;
            fetch_pc_q <= target_pc;
          end
        end
        WAIT: begin
          fetch_pc_q <= target_pc;
          if (imem_req_q && imem_gnt) imem_req_q <= 1'b0;
          if (rsp_ok) begin
            discard_q   <= 1'b0;
            state_q     <= room ? REQ : IDLE;
            imem_req_q  <= room;
            imem_addr_q <= room ? target_pc : imem_addr_q;
          end else if (redirect) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign imem_req      = imem_req_q;
  assign imem_addr     = imem_addr_q;
  assign inst_valid    = !empty;
  assign inst_encoding = inst_valid ? head.inst : INST_BUBBLE;
  assign pc            = inst_valid ? head.pc : 32'h0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner sequences and randomized stream check
module tb_fetch_unit;
  import rv_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic stall, redirect, imem_req, imem_gnt, imem_rvalid, inst_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, inst_encoding, pc;
  logic w_stall, w_redirect, w_req, w_gnt, w_rvalid, w_valid;
  logic [31:0] w_redirect_pc, w_addr, w_rdata, w_inst, w_pc;
  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_encoding(inst_encoding), .pc(pc), .inst_valid(inst_valid)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_w (
    .clk(clk), .rst(rst), .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .inst_encoding(w_inst), .pc(w_pc), .inst_valid(w_valid)
  );

  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_pc, pend_addr, prev_addr;
  int consumed = 0, resp_cnt = -1, gnt_pct = 100, lat_lo = 1, lat_hi = 1;
  bit block_gnt = 0, prev_req = 0, prev_gnt = 0;
  logic [31:0] w_q[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // one clock: drive inputs + memory responder, check the consumed stream, advance
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rp);
    bit g, cons;
    stall = st; redirect = rd; redirect_pc = rp;
    if (resp_cnt == 0) begin
      imem_rvalid = 1'b1; imem_rdata = mem(pend_addr); resp_cnt = -1;
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
      if (resp_cnt > 0) resp_cnt--;
    end
    g = imem_req && resp_cnt < 0 && !block_gnt && ($urandom_range(99) < gnt_pct);
    imem_gnt = g;
    if (g) begin
      pend_addr = imem_addr;
      resp_cnt = int'($urandom_range(lat_hi, lat_lo)) - 1;
    end
    cons = inst_valid && !st && !rd;
    if (cons) begin
      chk("consume_pc", pc, exp_pc);
      chk("consume_inst", inst_encoding, mem(exp_pc));
      exp_pc += 4;
      consumed++;
    end
    if (!inst_valid) chk("bubble", {inst_encoding, pc}, 64'h0);
    if (rd) exp_pc = {rp[31:2], 2'b00};
    prev_req = imem_req; prev_addr = imem_addr; prev_gnt = g;
    @(posedge clk); #1;
    if (rd) chk("valid_after_redirect", inst_valid, 0);
    if (prev_req && !prev_gnt) chk("req_hold", {imem_req, imem_addr}, {1'b1, prev_addr});
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 0; redirect = 0; redirect_pc = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; resp_cnt = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", imem_req, 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_valid", inst_valid, 0);
    chk("reset_out", {inst_encoding, pc}, 64'h0);
    rst = 1'b0; exp_pc = 32'h0; prev_req = 0;
  endtask

  task automatic wait_valid(input string nm, input logic [31:0] exp);
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid) begin found = 1; break; end
      cycle(0, 0, 0);
    end
    chk({nm, "_seen"}, found, 1);
    if (found) chk(nm, pc, exp);
  endtask

  task automatic wait_req(input string nm, input logic [31:0] not_addr, input logic [31:0] exp);
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_addr != not_addr) begin found = 1; break; end
      cycle(0, 0, 0);
    end
    chk({nm, "_seen"}, found, 1);
    if (found) chk(nm, imem_addr, exp);
  endtask

  typedef struct {
    bit st; bit rd; logic [31:0] rp;
    bit req; logic [31:0] addr; bit v; logic [31:0] opc;
  } vec_t;
  vec_t tbl[18];

  // dut_w: always-grant memory with one-cycle response latency, logging granted addresses
  initial begin
    w_stall = 0; w_redirect = 0; w_redirect_pc = 0;
    w_gnt = 0; w_rvalid = 0; w_rdata = 0;
    @(negedge rst);
    forever begin
      @(posedge clk); #1;
      w_rvalid = w_gnt;
      w_rdata = $urandom;
      w_gnt = w_req;
      if (w_gnt) w_q.push_back(w_addr);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] old;
    logic [31:0] wexp [3];
    int base;
    bit found;
    wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    for (int k = 0; k < 18; k++) tbl[k] = '{0, 0, 0, 0, 32'h4, 1, 0};
    tbl[0]  = '{1, 0, 0, 0, 32'h0, 0, 0};
    tbl[1]  = '{1, 0, 0, 1, 32'h0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 32'h0, 0, 0};
    tbl[3]  = '{1, 0, 0, 1, 32'h4, 1, 0};
    for (int k = 4; k < 10; k++) tbl[k] = '{1, 0, 0, 0, 32'h4, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 32'h4, 1, 32'h0};
    tbl[11] = '{0, 0, 0, 1, 32'h8, 1, 32'h4};
    tbl[12] = '{0, 0, 0, 0, 32'h8, 0, 0};
    tbl[13] = '{0, 1, 32'h100, 1, 32'hC, 1, 32'h8};
    tbl[14] = '{0, 0, 0, 0, 32'hC, 0, 0};
    tbl[15] = '{0, 0, 0, 1, 32'h100, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 32'h100, 0, 0};
    tbl[17] = '{0, 0, 0, 1, 32'h104, 1, 32'h100};
    rst = 1'b1;
    do_reset();
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("tbl%0d_req", k), imem_req, tbl[k].req);
      chk($sformatf("tbl%0d_addr", k), imem_addr, tbl[k].addr);
      chk($sformatf("tbl%0d_valid", k), inst_valid, tbl[k].v);
      chk($sformatf("tbl%0d_pc", k), pc, tbl[k].opc);
      if (tbl[k].v) chk($sformatf("tbl%0d_inst", k), inst_encoding, mem(tbl[k].opc));
      cycle(tbl[k].st, tbl[k].rd, tbl[k].rp);
    end

    // redirect in WAIT with a slow response for word 0x8
    do_reset();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_addr == 32'h8) begin found = 1; break; end
      cycle(0, 0, 0);
    end
    chk("A_req8_seen", found, 1);
    lat_lo = 3; lat_hi = 3;
    cycle(0, 0, 0);
    cycle(0, 1, 32'h100);
    lat_lo = 1; lat_hi = 1;
    wait_req("A_next_addr", 32'h8, 32'h100);
    wait_valid("A_first_pc", 32'h100);

    // redirect to unaligned target while the request waits for gnt
    block_gnt = 1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin found = 1; break; end
      cycle(0, 0, 0);
    end
    chk("B_req_seen", found, 1);
    old = imem_addr;
    cycle(0, 1, 32'h203);
    chk("B_hold1", {imem_req, imem_addr}, {1'b1, old});
    cycle(0, 0, 0);
    chk("B_hold2", {imem_req, imem_addr}, {1'b1, old});
    block_gnt = 0;
    wait_req("B_next_addr", old, 32'h200);
    wait_valid("B_first_pc", 32'h200);

    // full FIFO then stall+redirect together
    repeat (8) cycle(1, 0, 0);
    chk("C_full_valid", inst_valid, 1);
    chk("C_full_req", imem_req, 0);
    cycle(1, 1, 32'h40);
    wait_valid("C_first_pc", 32'h40);

    // async reset in WAIT, stale response returns after release
    lat_lo = 3; lat_hi = 3;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin found = 1; break; end
      cycle(0, 0, 0);
    end
    chk("D_req_seen", found, 1);
    cycle(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("D_async_req", imem_req, 0);
    chk("D_async_addr", imem_addr, 0);
    chk("D_async_valid", inst_valid, 0);
    chk("D_async_out", {inst_encoding, pc}, 64'h0);
    #1 rst = 1'b0;
    exp_pc = 32'h0; prev_req = 0;
    lat_lo = 1; lat_hi = 1;
    wait_valid("D_first_pc", 32'h0);
    chk("D_first_inst", inst_encoding, mem(32'h0));

    // randomized traffic against the stream model
    gnt_pct = 70; lat_lo = 1; lat_hi = 3;
    base = consumed;
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(99) < 30, $urandom_range(99) < 5, $urandom & 32'h0000_0FFF);
    chk("E_progress", (consumed - base) > 200, 1);

    chk("wrap_count", w_q.size() >= 3, 1);
    for (int i = 0; i < 3; i++)
      if (i < w_q.size()) chk($sformatf("wrap_addr%0d", i), w_q[i], wexp[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end; drives the inst_encoding/pc inputs of the fetch/decode pipeline register.
- Owns the fetch PC and issues word requests to instruction memory over a req/gnt + rvalid handshake, with at most one request outstanding.
- Buffers returned instructions in a small FIFO so a decode stall never loses a fetched word.
- Honours branch/jump redirects by discarding all stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, instruction FIFO entries (power of two, >=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- stall  input  1  decode stalled; hold current output word
- redirect  input  1  control transfer taken; restart fetch at redirect_pc
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
- imem_req  output  1  request valid
- imem_addr  output  32  word address of request
- imem_gnt  input  1  request accepted this cycle
- imem_rvalid  input  1  response data valid (>=1 cycle after gnt)
- imem_rdata  input  32  instruction word
- inst_encoding  output  32  instruction to decode; 32'b0 when inst_valid=0
- pc  output  32  address of inst_encoding; 32'b0 when inst_valid=0
- inst_valid  output  1  FIFO head valid

Behaviour:
- Reset (async, any time):
  - fetch_pc=RESET_PC; FIFO empty; state=IDLE; discard=0.
  - Outputs during and after reset: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_encoding=0, pc=0.
- States:
  - IDLE: assert nothing. Go to REQ when count+outstanding < BUF_DEPTH.
  - REQ: imem_req=1, imem_addr=fetch_pc, both held stable until imem_gnt. On gnt: fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go to WAIT.
  - WAIT: on imem_rvalid, either push {pc, rdata} to the FIFO or drop the word if discard=1 (then clear discard). Next state is REQ if room remains, else IDLE.
- Room check: a request may be issued only if (FIFO count + 1) <= BUF_DEPTH. The one outstanding request is counted, so the FIFO never overflows.
- Output side:
  - inst_encoding/pc/inst_valid are driven combinationally from the FIFO head.
  - Pop when inst_valid && !stall && !redirect.
  - Push and pop in the same cycle are legal; count is unchanged.
- Redirect (highest priority):
  - FIFO cleared; fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - inst_valid=0 from the next cycle.
  - Redirect in REQ without gnt: the request stays asserted with the old address until gnt (the address is not withdrawn); discard is set, the state goes to WAIT, and fetch_pc is not incremented.
  - Redirect in REQ with gnt: discard=1, state WAIT.
  - Redirect in WAIT without rvalid: discard=1.
  - Redirect in WAIT with rvalid: the word is dropped; discard stays 0; next state REQ.
  - Redirect in IDLE: next state REQ.
- stall and redirect together: redirect wins.
- The first valid instruction after a redirect reaches the output no earlier than 2 cycles after the redirect cycle (REQ with gnt, then rvalid, then visible).
- Minimum steady-state throughput: 1 word per 2 cycles with single-cycle memory (one outstanding request).
- imem_rvalid outside WAIT is a protocol error; it is ignored.

Decomposition:
- Shared package (rv_pkg):
  - XLEN=32.
  - INST_BUBBLE=32'h0000_0000.
  - PC_STEP=4.
  - Fetch state enum {IDLE, REQ, WAIT}.
- One sub-module: fetch_fifo.
  - Parameterised depth; stores {pc, inst}; ports push, pop, clear, full/empty, count.
  - clear has priority over push/pop.
  - Async reset to empty.

Test Plan:
- Reset release with gnt=1 and rvalid one cycle after gnt -> imem_addr sequence 0x0, 0x4, 0x8…; first output pc=0x0 with inst_valid=1; inst_encoding equals memory word 0.
- Hold stall=1 for 10 cycles -> the FIFO fills to 2 entries; imem_req stays 0 while full; the output holds pc=0x0; on release, pc advances 0x0 then 0x4 with no word lost or duplicated.
- Redirect to 0x100 while in WAIT (rvalid 3 cycles later, returning word for 0x8) -> the 0x8 word is dropped; the next imem_addr is 0x100; the first valid output is pc=0x100.
- Redirect to 0x203 while imem_req=1 and gnt=0 -> imem_addr holds the old address until gnt; that response is discarded; the next request address is 0x200.
- Redirect and stall asserted together, FIFO full -> inst_valid=0 next cycle; the old entries are never output.
- RESET_PC=32'hFFFF_FFF8 -> requests at 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
- Assert rst mid-WAIT -> outputs return to reset values immediately, without waiting for a clock edge; a late rvalid arriving after rst deasserts is ignored.
